// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - shared types and width helpers for the dual-port on-chip RAM
// Contents: clear/run FSM state type, byte-enable and word-address width
// derivations, and the collision priority constant.
package onchip_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_t;

    // On a same-word collision involving a write, port A (CPU) goes first.
    localparam logic PRIO_A = 1'b1;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int wa_width(input int addr_width, input int data_width);
        return addr_width - $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/onchip_ram_dp_bank.sv
// rtl/onchip_ram_dp_bank.sv - inferred true-dual-port array with byte write enables
// Ports (per side x = a/b):
//   clock      rising-edge clock
//   x_we       per-byte write enables (all zero = no write)
//   x_re       read enable, loads the first read register
//   x_addr     word address
//   x_wdata    write data
//   x_rdata    read data, valid READ_LATENCY cycles after x_re
module onchip_ram_dp_bank #(
    parameter int  DATA_WIDTH   = 16,
    parameter int  WA_W         = 11,
    parameter int  READ_LATENCY = 1,
    localparam int BE_W         = DATA_WIDTH / 8,
    localparam int DEPTH        = 2 ** WA_W
) (
    input  logic                  clock,
    input  logic [BE_W-1:0]       a_we,
    input  logic                  a_re,
    input  logic [WA_W-1:0]       a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic [BE_W-1:0]       b_we,
    input  logic                  b_re,
    input  logic [WA_W-1:0]       b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] a_rd1;
    logic [DATA_WIDTH-1:0] b_rd1;

    // The two ports never write the same word in one cycle, so ordering
    // inside this block carries no meaning.
    always_ff @(posedge clock) begin
        for (int i = 0; i < BE_W; i++) begin
            if (a_we[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            if (b_we[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (a_re) a_rd1 <= mem[a_addr];
        if (b_re) b_rd1 <= mem[b_addr];
    end

    generate
        if (READ_LATENCY == 2) begin : g_oreg
            logic [DATA_WIDTH-1:0] a_rd2;
            logic [DATA_WIDTH-1:0] b_rd2;
            always_ff @(posedge clock) begin
                a_rd2 <= a_rd1;
                b_rd2 <= b_rd1;
            end
            assign a_rdata = a_rd2;
            assign b_rdata = b_rd2;
        end else begin : g_direct
            assign a_rdata = a_rd1;
            assign b_rdata = b_rd1;
        end
    endgenerate

endmodule

// File: rtl/onchip_ram_dp.sv
// rtl/onchip_ram_dp.sv - true-dual-port on-chip RAM with req/ack handshakes and clear sequencer
// Ports:
//   clock, rst_n        clock and asynchronous active-low reset
//   init_busy           high while the post-reset clear sequence runs
//   x_req               request, held until x_ack (x = a: CPU, b: DMA/video)
//   x_wren              1 = write, 0 = read
//   x_byteena           byte enables for writes
//   x_address           word address
//   x_data              write data
//   x_q                 read data, updated on read ack and held otherwise
//   x_ack               one-cycle completion pulse
module onchip_ram_dp
    import onchip_ram_pkg::*;
#(
    parameter int  ADDR_WIDTH     = 12,
    parameter int  DATA_WIDTH     = 16,
    parameter int  READ_LATENCY   = 1,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int BE_W           = be_width(DATA_WIDTH),
    localparam int WA_W           = wa_width(ADDR_WIDTH, DATA_WIDTH)
) (
    input  logic                  clock,
    input  logic                  rst_n,
    output logic                  init_busy,
    input  logic                  a_req,
    input  logic                  a_wren,
    input  logic [BE_W-1:0]       a_byteena,
    input  logic [WA_W-1:0]       a_address,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic [DATA_WIDTH-1:0] a_q,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_wren,
    input  logic [BE_W-1:0]       b_byteena,
    input  logic [WA_W-1:0]       b_address,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [DATA_WIDTH-1:0] b_q,
    output logic                  b_ack
);

    localparam int DEPTH = 2 ** WA_W;

    ram_state_t state, state_nxt;
    logic [WA_W-1:0] clr_cnt;

    logic run;
    logic a_busy, b_busy;
    logic a_elig, b_elig, collide;
    logic a_acc, b_acc;
    logic a_wack, b_wack;
    logic [READ_LATENCY-1:0] a_rpipe, b_rpipe;
    logic a_rack, b_rack;
    logic [DATA_WIDTH-1:0] a_hold, b_hold;

    logic [BE_W-1:0]       bank_a_we, bank_b_we;
    logic [WA_W-1:0]       bank_a_addr;
    logic [DATA_WIDTH-1:0] bank_a_wdata;
    logic [DATA_WIDTH-1:0] bank_a_rdata, bank_b_rdata;

    // Clear sequencer
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        init_busy = 1'b0;
        case (state)
            ST_CLEAR: begin
                init_busy = 1'b1;
                if (clr_cnt == WA_W'(DEPTH - 1)) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Acceptance and collision arbitration. rst_n gates run so nothing is
    // accepted (and no write lands) while reset is held.
    assign run     = (state == ST_RUN) && rst_n;
    assign a_elig  = run && a_req && !a_busy;
    assign b_elig  = run && b_req && !b_busy;
    assign collide = a_elig && b_elig && (a_address == b_address) && (a_wren || b_wren);
    assign a_acc   = a_elig && !(collide && !PRIO_A);
    assign b_acc   = b_elig && !(collide && PRIO_A);

    // The clear sequencer borrows port A of the array.
    always_comb begin
        bank_a_we    = '0;
        bank_a_addr  = a_address;
        bank_a_wdata = a_data;
        if (state == ST_CLEAR) begin
            bank_a_we    = '1;
            bank_a_addr  = clr_cnt;
            bank_a_wdata = '0;
        end else if (a_acc && a_wren) begin
            bank_a_we = a_byteena;
        end
    end

    always_comb begin
        bank_b_we = '0;
        if (b_acc && b_wren) bank_b_we = b_byteena;
    end

    onchip_ram_dp_bank #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WA_W         (WA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_bank (
        .clock   (clock),
        .a_we    (bank_a_we),
        .a_re    (a_acc && !a_wren),
        .a_addr  (bank_a_addr),
        .a_wdata (bank_a_wdata),
        .a_rdata (bank_a_rdata),
        .b_we    (bank_b_we),
        .b_re    (b_acc && !b_wren),
        .b_addr  (b_address),
        .b_wdata (b_data),
        .b_rdata (bank_b_rdata)
    );

    // Handshake tracking: writes ack after one cycle, reads after the
    // read pipeline; busy covers acceptance through ack.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            a_busy  <= 1'b0;
            b_busy  <= 1'b0;
            a_wack  <= 1'b0;
            b_wack  <= 1'b0;
            a_rpipe <= '0;
            b_rpipe <= '0;
            a_hold  <= '0;
            b_hold  <= '0;
        end else begin
            a_wack  <= a_acc && a_wren;
            b_wack  <= b_acc && b_wren;
            a_rpipe <= (a_rpipe << 1) | READ_LATENCY'(a_acc && !a_wren);
            b_rpipe <= (b_rpipe << 1) | READ_LATENCY'(b_acc && !b_wren);
            if (a_acc)      a_busy <= 1'b1;
            else if (a_ack) a_busy <= 1'b0;
            if (b_acc)      b_busy <= 1'b1;
            else if (b_ack) b_busy <= 1'b0;
            if (a_rack) a_hold <= bank_a_rdata;
            if (b_rack) b_hold <= bank_b_rdata;
        end
    end

    assign a_rack = a_rpipe[READ_LATENCY-1];
    assign b_rack = b_rpipe[READ_LATENCY-1];
    assign a_ack  = a_wack || a_rack;
    assign b_ack  = b_wack || b_rack;

    // Fresh array data is forwarded on the ack cycle itself; the hold
    // register keeps it until the next read ack on that port.
    assign a_q = a_rack ? bank_a_rdata : a_hold;
    assign b_q = b_rack ? bank_b_rdata : b_hold;

endmodule

// File: tb/tb_onchip_ram_dp.sv
// tb/tb_onchip_ram_dp.sv - self-checking bench for onchip_ram_dp
module tb_onchip_ram_dp;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance 0: 4KB x16, latency 1, clear on reset (2048 words)
    logic              rst0_n;
    logic              busy0;
    logic [1:0]        req0, wren0, ack0;
    logic [1:0][1:0]   be0;
    logic [1:0][10:0]  addr0;
    logic [1:0][15:0]  wd0, q0;

    // Instance 1: 1KB x32, latency 2, no clear (256 words)
    logic              rst1_n;
    logic              busy1;
    logic [1:0]        req1, wren1, ack1;
    logic [1:0][3:0]   be1;
    logic [1:0][7:0]   addr1;
    logic [1:0][31:0]  wd1, q1;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] sb [4][$];

    onchip_ram_dp #(
        .ADDR_WIDTH(12), .DATA_WIDTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clock(clock), .rst_n(rst0_n), .init_busy(busy0),
        .a_req(req0[0]), .a_wren(wren0[0]), .a_byteena(be0[0]), .a_address(addr0[0]),
        .a_data(wd0[0]), .a_q(q0[0]), .a_ack(ack0[0]),
        .b_req(req0[1]), .b_wren(wren0[1]), .b_byteena(be0[1]), .b_address(addr0[1]),
        .b_data(wd0[1]), .b_q(q0[1]), .b_ack(ack0[1])
    );

    onchip_ram_dp #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(2), .CLEAR_ON_RESET(0)
    ) dut1 (
        .clock(clock), .rst_n(rst1_n), .init_busy(busy1),
        .a_req(req1[0]), .a_wren(wren1[0]), .a_byteena(be1[0]), .a_address(addr1[0]),
        .a_data(wd1[0]), .a_q(q1[0]), .a_ack(ack1[0]),
        .b_req(req1[1]), .b_wren(wren1[1]), .b_byteena(be1[1]), .b_address(addr1[1]),
        .b_data(wd1[1]), .b_q(q1[1]), .b_ack(ack1[1])
    );

    function automatic logic ackv(input int d, input int p);
        return (d == 0) ? ack0[p] : ack1[p];
    endfunction

    function automatic logic [31:0] qv(input int d, input int p);
        return (d == 0) ? {16'h0000, q0[p]} : q1[p];
    endfunction

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    // One transaction on dut d, port p; starts and ends just after a rising edge.
    task automatic op(input int d, input int p, input bit wr, input logic [3:0] be,
                      input logic [10:0] addr, input logic [31:0] data,
                      input logic [31:0] expq, input int exp_lat, input string name);
        int n;
        bit got;
        logic [31:0] e;
        if (!wr) sb[d*2+p].push_back(expq);
        if (d == 0) begin
            req0[p] = 1'b1; wren0[p] = wr; be0[p] = be[1:0];
            addr0[p] = addr; wd0[p] = data[15:0];
        end else begin
            req1[p] = 1'b1; wren1[p] = wr; be1[p] = be;
            addr1[p] = addr[7:0]; wd1[p] = data;
        end
        n = 0;
        got = 1'b0;
        while (!got && n <= 20) begin
            @(negedge clock);
            if (ackv(d, p)) got = 1'b1;
            else n++;
        end
        compared++;
        if (!got || n != exp_lat) begin
            mismatched++;
            $display("FAIL %s latency: got %0d (acked=%0b) want %0d", name, n, got, exp_lat);
        end
        if (!wr) begin
            e = sb[d*2+p].pop_front();
            if (got) begin
                compared++;
                if (qv(d, p) !== e) begin
                    mismatched++;
                    $display("FAIL %s q: got %h want %h", name, qv(d, p), e);
                end
            end
        end
        sync();
        if (d == 0) req0[p] = 1'b0;
        else        req1[p] = 1'b0;
    endtask

    task automatic test_reset();
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        compared += 6;
        if (busy0 !== 1'b1) begin mismatched++; $display("FAIL rst busy0: got %b want 1", busy0); end
        if (busy1 !== 1'b0) begin mismatched++; $display("FAIL rst busy1: got %b want 0", busy1); end
        if (q0 !== '0) begin mismatched++; $display("FAIL rst q0: got %h want 0", q0); end
        if (q1 !== '0) begin mismatched++; $display("FAIL rst q1: got %h want 0", q1); end
        if (ack0 !== 2'b00) begin mismatched++; $display("FAIL rst ack0: got %b want 00", ack0); end
        if (ack1 !== 2'b00) begin mismatched++; $display("FAIL rst ack1: got %b want 00", ack1); end
    endtask

    task automatic test_clear();
        int cnt;
        sync();
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        cnt = 0;
        @(negedge clock);
        compared++;
        if (busy1 !== 1'b0) begin mismatched++; $display("FAIL noclear busy1: got %b want 0", busy1); end
        while (busy0 === 1'b1 && cnt < 5000) begin
            cnt++;
            @(negedge clock);
        end
        compared++;
        if (cnt != 2048) begin mismatched++; $display("FAIL clear cycles: got %0d want 2048", cnt); end
        sync();
        foreach (addr0[p]) begin
            op(0, p, 1'b0, 4'h3, 11'd0,    32'h0, 32'h0, 1, "clr_w0");
            op(0, p, 1'b0, 4'h3, 11'd1023, 32'h0, 32'h0, 1, "clr_w1023");
            op(0, p, 1'b0, 4'h3, 11'd2047, 32'h0, 32'h0, 1, "clr_w2047");
        end
    endtask

    task automatic test_byte_write();
        op(0, 0, 1'b1, 4'b01, 11'd5, 32'hABCD, 32'h0,    1, "bw_wr");
        op(0, 0, 1'b0, 4'b00, 11'd5, 32'h0,    32'h00CD, 1, "bw_rd");
        op(0, 0, 1'b1, 4'b00, 11'd5, 32'hFFFF, 32'h0,    1, "bw_noop_wr");
        op(0, 1, 1'b0, 4'b00, 11'd5, 32'h0,    32'h00CD, 1, "bw_noop_rd");
        op(0, 0, 1'b1, 4'b10, 11'd5, 32'h9900, 32'h0,    1, "bw_hi_wr");
        op(0, 0, 1'b0, 4'b00, 11'd5, 32'h0,    32'h99CD, 1, "bw_hi_rd");
    endtask

    task automatic test_collision();
        fork
            op(0, 0, 1'b1, 4'b11, 11'd9, 32'h1111, 32'h0, 1, "col_a_wr");
            op(0, 1, 1'b1, 4'b11, 11'd9, 32'h2222, 32'h0, 2, "col_b_wr");
        join
        op(0, 0, 1'b0, 4'b11, 11'd9, 32'h0, 32'h2222, 1, "col_rd");
        fork
            op(0, 0, 1'b0, 4'b11, 11'd9, 32'h0, 32'h2222, 1, "rr_a");
            op(0, 1, 1'b0, 4'b11, 11'd9, 32'h0, 32'h2222, 1, "rr_b");
        join
        fork
            op(0, 0, 1'b1, 4'b11, 11'd3, 32'h5555, 32'h0,    1, "mix_a_wr");
            op(0, 1, 1'b0, 4'b11, 11'd3, 32'h0,    32'h5555, 2, "mix_b_rd");
        join
        fork
            op(0, 0, 1'b1, 4'b11, 11'd20, 32'h7777, 32'h0, 1, "par_a_wr");
            op(0, 1, 1'b0, 4'b11, 11'd21, 32'h0,    32'h0, 1, "par_b_rd");
        join
        op(0, 1, 1'b0, 4'b11, 11'd20, 32'h0, 32'h7777, 1, "par_chk");
    endtask

    task automatic test_latency2();
        op(1, 1, 1'b1, 4'hF, 11'd7, 32'hDEADBEEF, 32'h0,        1, "l2_wr");
        op(1, 1, 1'b0, 4'hF, 11'd7, 32'h0,        32'hDEADBEEF, 2, "l2_rd");
        op(1, 1, 1'b1, 4'hF, 11'd8, 32'hCAFEF00D, 32'h0,        1, "l2_wr8");
        compared++;
        if (q1[1] !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL hold_after_wr: got %h want deadbeef", q1[1]);
        end
        op(1, 0, 1'b0, 4'hF, 11'd8, 32'h0, 32'hCAFEF00D, 2, "l2_a_rd8");
        compared++;
        if (q1[1] !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL hold_after_xrd: got %h want deadbeef", q1[1]);
        end
        op(1, 1, 1'b1, 4'b1010, 11'd7, 32'h11223344, 32'h0,        1, "l2_be_wr");
        op(1, 1, 1'b0, 4'hF,    11'd7, 32'h0,        32'h11AD33EF, 2, "l2_be_rd");
    endtask

    task automatic test_reset_mid_read();
        int acks;
        op(1, 0, 1'b1, 4'hF, 11'd20, 32'h12345678, 32'h0, 1, "rmr_wr");
        op(1, 0, 1'b0, 4'hF, 11'd20, 32'h0, 32'h12345678, 2, "rmr_pre_rd");
        req1[0] = 1'b1; wren1[0] = 1'b0; addr1[0] = 8'd7;
        sync();
        rst1_n = 1'b0;
        req1[0] = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clock);
            if (ack1[0] === 1'b1) acks++;
        end
        compared += 2;
        if (acks != 0) begin mismatched++; $display("FAIL rmr_ack: got %0d acks want 0", acks); end
        if (q1[0] !== 32'h0) begin mismatched++; $display("FAIL rmr_q: got %h want 0", q1[0]); end
        sync();
        rst1_n = 1'b1;
        sync();
        op(1, 0, 1'b0, 4'hF, 11'd20, 32'h0, 32'h12345678, 2, "rmr_keep20");
        op(1, 1, 1'b0, 4'hF, 11'd7,  32'h0, 32'h11AD33EF, 2, "rmr_keep7");
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        req0 = '0; wren0 = '0; be0 = '0; addr0 = '0; wd0 = '0;
        req1 = '0; wren1 = '0; be1 = '0; addr1 = '0; wd1 = '0;
        test_reset();
        test_clear();
        test_byte_write();
        test_collision();
        test_latency2();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
